// File: rtl/vga_bounce_box.sv
// Pixel generator behind vga_control: a solid square that bounces around the active area.
// Colour and syncs share a 2-cycle pipeline so they stay aligned at the pins.
module vga_bounce_box #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned BOX_SIZE  = 32,
    parameter int unsigned STEP      = 2,
    parameter int unsigned INIT_X    = 0,
    parameter int unsigned INIT_Y    = 0,
    parameter logic [2:0]  BG_COLOR  = 3'b001,
    parameter logic [2:0]  BOX_COLOR = 3'b110
) (
    input  logic       clk_25,
    input  logic       reset,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic       bright,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    output logic [2:0] rgb,
    output logic       hs,
    output logic       vs,
    output logic       frame_tick
);

    localparam logic [10:0] HA     = 11'(H_ACTIVE);
    localparam logic [10:0] VA     = 11'(V_ACTIVE);
    localparam logic [10:0] SZ     = 11'(BOX_SIZE);
    localparam logic [10:0] ST     = 11'(STEP);
    localparam logic [9:0]  ST10   = 10'(STEP);
    localparam logic [9:0]  X_MAX  = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0]  Y_MAX  = 10'(V_ACTIVE - BOX_SIZE);
    localparam logic [9:0]  X_INIT = 10'(INIT_X);
    localparam logic [9:0]  Y_INIT = 10'(INIT_Y);
    localparam logic [9:0]  V_TRIG = 10'(V_ACTIVE);

    // dir_*_q: 1 = moving towards larger coordinates
    logic [9:0] box_x_q, box_x_d, box_y_q, box_y_d;
    logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic       in_box_q, bright_q, hs_q, vs_q;
    logic       trigger, in_box;

    assign trigger = (h_count == 10'd0) && (v_count == V_TRIG);

    // 11-bit compares so box edge + size never wraps
    assign in_box = ({1'b0, h_count} >= {1'b0, box_x_q}) &&
                    ({1'b0, h_count} <  ({1'b0, box_x_q} + SZ)) &&
                    ({1'b0, v_count} >= {1'b0, box_y_q}) &&
                    ({1'b0, v_count} <  ({1'b0, box_y_q} + SZ));

    always_comb begin
        box_x_d = box_x_q;
        box_y_d = box_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (trigger) begin
            if (dir_x_q) begin
                if (({1'b0, box_x_q} + ST + SZ) > HA) begin
                    box_x_d = X_MAX;
                    dir_x_d = 1'b0;
                end else begin
                    box_x_d = box_x_q + ST10;
                end
            end else begin
                if ({1'b0, box_x_q} < ST) begin
                    box_x_d = '0;
                    dir_x_d = 1'b1;
                end else begin
                    box_x_d = box_x_q - ST10;
                end
            end
            if (dir_y_q) begin
                if (({1'b0, box_y_q} + ST + SZ) > VA) begin
                    box_y_d = Y_MAX;
                    dir_y_d = 1'b0;
                end else begin
                    box_y_d = box_y_q + ST10;
                end
            end else begin
                if ({1'b0, box_y_q} < ST) begin
                    box_y_d = '0;
                    dir_y_d = 1'b1;
                end else begin
                    box_y_d = box_y_q - ST10;
                end
            end
        end
    end

    always_ff @(posedge clk_25) begin
        if (reset) begin
            box_x_q    <= X_INIT;
            box_y_q    <= Y_INIT;
            dir_x_q    <= 1'b1;
            dir_y_q    <= 1'b1;
            in_box_q   <= 1'b0;
            bright_q   <= 1'b0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            rgb        <= 3'b000;
            hs         <= 1'b1;
            vs         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            box_x_q    <= box_x_d;
            box_y_q    <= box_y_d;
            dir_x_q    <= dir_x_d;
            dir_y_q    <= dir_y_d;
            in_box_q   <= in_box;
            bright_q   <= bright;
            hs_q       <= h_sync_in;
            vs_q       <= v_sync_in;
            rgb        <= !bright_q ? 3'b000 : (in_box_q ? BOX_COLOR : BG_COLOR);
            hs         <= hs_q;
            vs         <= vs_q;
            frame_tick <= trigger;
        end
    end

endmodule

// File: tb/tb_vga_bounce_box.sv
// Bench for vga_bounce_box: two instances (default start, start near the right edge) checked
// against a pixel/position model built from signed positions and velocities.
module tb_vga_bounce_box;

    localparam logic [2:0] BGC  = 3'b001;
    localparam logic [2:0] BOXC = 3'b110;

    logic       clk_25 = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] h_count = '0;
    logic [9:0] v_count = '0;
    logic       bright = 1'b0;
    logic       h_sync_in = 1'b1;
    logic       v_sync_in = 1'b1;
    logic [2:0] rgb0, rgb1;
    logic       hs0, vs0, ft0, hs1, vs1, ft1;

    always #5 clk_25 = ~clk_25;

    vga_bounce_box dut0 (
        .clk_25(clk_25), .reset(reset), .h_count(h_count), .v_count(v_count),
        .bright(bright), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .rgb(rgb0), .hs(hs0), .vs(vs0), .frame_tick(ft0)
    );

    vga_bounce_box #(.INIT_X(607), .INIT_Y(1)) dut1 (
        .clk_25(clk_25), .reset(reset), .h_count(h_count), .v_count(v_count),
        .bright(bright), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .rgb(rgb1), .hs(hs1), .vs(vs1), .frame_tick(ft1)
    );

    int tests_run = 0;
    int failures = 0;

    // Model state: box position and signed velocity per instance
    int   p_ix[2] = '{0, 607};
    int   p_iy[2] = '{1 - 1, 1};
    int   mx[2], my[2], mvx[2], mvy[2];
    bit   p1_box[2];
    bit   p1_b, p1_hs, p1_vs;
    logic [2:0] e_rgb[2];
    bit   e_tick[2];
    bit   e_hs, e_vs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void bounce(inout int p, inout int vel, input int lim);
        p = p + vel;
        if (p + 32 > lim) begin
            p = lim - 32;
            vel = -vel;
        end else if (p < 0) begin
            p = 0;
            vel = -vel;
        end
    endfunction

    task automatic cycle(input int h, input int v, input bit b, input bit hsi, input bit vsi,
                         input bit rst);
        bit trig;
        int tx, tv;
        h = h & 1023;
        v = v & 1023;
        h_count = 10'(h);
        v_count = 10'(v);
        bright = b;
        h_sync_in = hsi;
        v_sync_in = vsi;
        reset = rst;
        trig = (h == 0) && (v == 480);
        @(posedge clk_25);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                e_rgb[i] = 3'b000;
                p1_box[i] = 1'b0;
                e_tick[i] = 1'b0;
                mx[i] = p_ix[i];
                my[i] = p_iy[i];
                mvx[i] = 2;
                mvy[i] = 2;
            end else begin
                e_rgb[i] = !p1_b ? 3'b000 : (p1_box[i] ? BOXC : BGC);
                p1_box[i] = (h >= mx[i]) && (h < mx[i] + 32) && (v >= my[i]) && (v < my[i] + 32);
                e_tick[i] = trig;
                if (trig) begin
                    tx = mx[i]; tv = mvx[i]; bounce(tx, tv, 640); mx[i] = tx; mvx[i] = tv;
                    tx = my[i]; tv = mvy[i]; bounce(tx, tv, 480); my[i] = tx; mvy[i] = tv;
                end
            end
        end
        if (rst) begin
            e_hs = 1'b1; e_vs = 1'b1; p1_b = 1'b0; p1_hs = 1'b1; p1_vs = 1'b1;
        end else begin
            e_hs = p1_hs; e_vs = p1_vs; p1_b = b; p1_hs = hsi; p1_vs = vsi;
        end
        #1;
        check("rgb0", rgb0, e_rgb[0]);
        check("rgb1", rgb1, e_rgb[1]);
        check("tick0", ft0, e_tick[0]);
        check("tick1", ft1, e_tick[1]);
        check("hs0", hs0, e_hs);
        check("vs0", vs0, e_vs);
        check("hs1", hs1, e_hs);
        check("vs1", vs1, e_vs);
    endtask

    task automatic probe(input string tag, input int h, input int v, input bit b,
                         input logic [2:0] x0, input logic [2:0] x1);
        cycle(h, v, b, 1'b1, 1'b1, 1'b0);
        cycle(700, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        check({tag, "_d0"}, rgb0, x0);
        check({tag, "_d1"}, rgb1, x1);
    endtask

    task automatic trigger_frame();
        cycle(0, 480, 1'b0, 1'b1, 1'b1, 1'b0);
        check("ft_pulse0", ft0, 1'b1);
        check("ft_pulse1", ft1, 1'b1);
        cycle(1, 480, 1'b0, 1'b1, 1'b1, 1'b0);
        check("ft_low0", ft0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            cycle(int'($urandom_range(0, 1023)), 5, 1'b1, 1'b0, 1'b0, 1'b1);
            check("rst_rgb", rgb0, 3'b000);
            check("rst_hs", hs0, 1'b1);
            check("rst_vs", vs0, 1'b1);
        end

        probe("px_0_0", 0, 0, 1'b1, BOXC, BGC);
        probe("px_32_0", 32, 0, 1'b1, BGC, BGC);
        probe("px_31_31", 31, 31, 1'b1, BOXC, BGC);
        probe("px_607_1", 607, 1, 1'b1, BGC, BOXC);

        trigger_frame();
        probe("r1_608_3", 608, 3, 1'b1, BGC, BOXC);
        probe("r1_607_3", 607, 3, 1'b1, BGC, BGC);
        probe("r1_639_34", 639, 34, 1'b1, BGC, BOXC);

        trigger_frame();
        probe("r2_606_5", 606, 5, 1'b1, BGC, BOXC);
        probe("r2_638_5", 638, 5, 1'b1, BGC, BGC);
        probe("r2_637_5", 637, 5, 1'b1, BGC, BOXC);

        trigger_frame();
        probe("m3_5_5", 5, 5, 1'b1, BGC, BGC);
        probe("m3_6_6", 6, 6, 1'b1, BOXC, BGC);
        probe("m3_37_37", 37, 37, 1'b1, BOXC, BGC);
        probe("m3_38_37", 38, 37, 1'b1, BGC, BGC);
        probe("dark_10_10", 10, 10, 1'b0, 3'b000, 3'b000);

        // Reset while a box pixel is in flight
        cycle(10, 10, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(20, 20, 1'b1, 1'b0, 1'b0, 1'b1);
        check("midrst_rgb", rgb0, 3'b000);
        check("midrst_hs", hs0, 1'b1);
        check("midrst_vs", vs0, 1'b1);
        probe("post_rst_0_0", 0, 0, 1'b1, BOXC, BGC);
        probe("post_rst_607_1", 607, 1, 1'b1, BGC, BOXC);

        // Long random run, no reset: many triggers so every wall and corner is reached
        for (int n = 0; n < 7000; n++) begin
            int r, h, v, k;
            r = int'($urandom_range(0, 99));
            k = int'($urandom_range(0, 1));
            if (r < 20) begin
                h = 0; v = 480;
            end else if (r < 65) begin
                h = mx[k] + int'($urandom_range(0, 35)) - 2;
                v = my[k] + int'($urandom_range(0, 35)) - 2;
            end else if (r < 72) begin
                h = 1023; v = my[k] + int'($urandom_range(0, 31));
            end else begin
                h = int'($urandom_range(0, 1023)); v = int'($urandom_range(0, 1023));
            end
            cycle(h, v, $urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), 1'b0);
        end

        // Random run with occasional reset, including reset coinciding with a trigger
        for (int n = 0; n < 800; n++) begin
            int r, h, v;
            r = int'($urandom_range(0, 99));
            if (r < 25) begin
                h = 0; v = 480;
            end else begin
                h = mx[0] + int'($urandom_range(0, 40)) - 4;
                v = my[0] + int'($urandom_range(0, 40)) - 4;
            end
            cycle(h, v, $urandom_range(0, 5) != 0, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 24) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
